sram_req_arbiter: RTL and testbench

Two-requester arbiter that shares a single SRAM-like memory port between the instruction-fetch and data-access SRAM-like interfaces of the CPU core. It sits between the core's `inst_sram_*` / `data_sram_*` ports and one downstream `mem_sram_*` port, typically an AXI bridge. An in-order owner FIFO tracks up to `OT_DEPTH` outstanding accepted requests, so each `data_ok`/`rdata` return is steered back to the requester that issued it.

---
 rtl/sram_req_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// ============================================================================
// Module   : sram_req_arbiter
// Brief    : Shares one SRAM-like port between inst and data requesters and
//            steers returns back through an in-order owner FIFO.
//            Define SRAM_ARB_RR_EN for round-robin grant (default: data wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_req_arbiter #(
   parameter int OT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic        mem_sram_req,
   output logic        mem_sram_wr,
   output logic [1:0]  mem_sram_size,
   output logic [31:0] mem_sram_addr,
   output logic [3:0]  mem_sram_wstrb,
   output logic [31:0] mem_sram_wdata,
   input  logic        mem_sram_addr_ok,
   input  logic        mem_sram_data_ok,
   input  logic [31:0] mem_sram_rdata
);

   localparam int PTR_W = $clog2(OT_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(OT_DEPTH);

   logic                r_lock_vld;
   logic                r_lock_sel;
   logic [OT_DEPTH-1:0] r_owner;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic                r_full;
`ifdef SRAM_ARB_RR_EN
   logic                r_rr_ptr;
`endif

   logic                w_sel;      // 1 = data port granted
   logic                w_req;
   logic                w_push;
   logic                w_pop;
   logic                w_head;
   logic [CNT_W-1:0]    w_cnt_nxt;

   always_comb begin
      w_sel = 1'b0;
      if (r_lock_vld)
         w_sel = r_lock_sel;
`ifdef SRAM_ARB_RR_EN
      else if (inst_sram_req && data_sram_req)
         w_sel = r_rr_ptr;
`endif
      else
         w_sel = data_sram_req;
   end

   always_comb begin
      w_req          = w_sel ? data_sram_req   : inst_sram_req;
      mem_sram_wr    = w_sel ? data_sram_wr    : inst_sram_wr;
      mem_sram_size  = w_sel ? data_sram_size  : inst_sram_size;
      mem_sram_addr  = w_sel ? data_sram_addr  : inst_sram_addr;
      mem_sram_wstrb = w_sel ? data_sram_wstrb : inst_sram_wstrb;
      mem_sram_wdata = w_sel ? data_sram_wdata : inst_sram_wdata;
   end

   // full is a registered flag, so a pop never enables a push in the same cycle
   assign mem_sram_req      = w_req & ~r_full & ~reset;
   assign w_push            = mem_sram_req & mem_sram_addr_ok;
   assign inst_sram_addr_ok = w_push & ~w_sel;
   assign data_sram_addr_ok = w_push &  w_sel;

   assign w_head            = r_owner[r_rd_ptr];
   assign w_pop             = mem_sram_data_ok & (r_count != '0) & ~reset;
   assign inst_sram_data_ok = w_pop & ~w_head;
   assign data_sram_data_ok = w_pop &  w_head;
   assign inst_sram_rdata   = mem_sram_rdata;
   assign data_sram_rdata   = mem_sram_rdata;

   assign w_cnt_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_vld <= 1'b0;
         r_lock_sel <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
      end else begin
         // holds the grant while the downstream stalls a presented request
         r_lock_vld <= mem_sram_req & ~mem_sram_addr_ok;
         r_lock_sel <= w_sel;
         if (w_push) begin
            r_owner[r_wr_ptr] <= w_sel;
            r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == C_FULL_CNT);
      end
   end

`ifdef SRAM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset)
         r_rr_ptr <= 1'b0;
      else if (w_push)
         r_rr_ptr <= ~w_sel;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
// ============================================================================
// Module   : tb_sram_req_arbiter
// Brief    : Directed self-checking bench for sram_req_arbiter (fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req, inst_sram_wr, data_sram_req, data_sram_wr;
   logic [1:0]  inst_sram_size, data_sram_size, mem_sram_size;
   logic [31:0] inst_sram_addr, data_sram_addr, mem_sram_addr;
   logic [3:0]  inst_sram_wstrb, data_sram_wstrb, mem_sram_wstrb;
   logic [31:0] inst_sram_wdata, data_sram_wdata, mem_sram_wdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] inst_sram_rdata, data_sram_rdata, mem_sram_rdata;
   logic        mem_sram_req, mem_sram_wr, mem_sram_addr_ok, mem_sram_data_ok;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sram_req_arbiter #(.OT_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
      .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
      .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .mem_sram_req(mem_sram_req), .mem_sram_wr(mem_sram_wr),
      .mem_sram_size(mem_sram_size), .mem_sram_addr(mem_sram_addr),
      .mem_sram_wstrb(mem_sram_wstrb), .mem_sram_wdata(mem_sram_wdata),
      .mem_sram_addr_ok(mem_sram_addr_ok), .mem_sram_data_ok(mem_sram_data_ok),
      .mem_sram_rdata(mem_sram_rdata)
   );

   // inputs change at the falling edge, outputs are sampled 1 ns later
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic idle();
      inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = 32'h1c00_0000;
      inst_sram_wstrb = 4'h0; inst_sram_wdata = 32'h0;
      data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 32'h8000_0000;
      data_sram_wstrb = 4'h0; data_sram_wdata = 32'h0;
      mem_sram_addr_ok = 0; mem_sram_data_ok = 0; mem_sram_rdata = 32'h0;
   endtask

   task automatic test_reset();
      next_cycle();
      reset = 1; inst_sram_req = 1; data_sram_req = 1; mem_sram_addr_ok = 1; mem_sram_data_ok = 1;
      #1;
      n_chk++; if (mem_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_sram_req); end
      n_chk++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_addr_ok: got %b expected 00", {inst_sram_addr_ok, data_sram_addr_ok}); end
      n_chk++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_data_ok: got %b expected 00", {inst_sram_data_ok, data_sram_data_ok}); end
      next_cycle(); next_cycle();
      reset = 0; idle();
      #1;
      n_chk++; if (mem_sram_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_req: got %b expected 0", mem_sram_req); end
   endtask

   task automatic test_priority();
      logic [3:0] exp_data = 4'b0111;   // three data accepts, then inst alone
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         idle();
         inst_sram_req = 1; inst_sram_addr = 32'h1c00_0100 + 32'(i*4);
         data_sram_req = (i < 3); data_sram_addr = 32'h8000_0200 + 32'(i*4);
         mem_sram_addr_ok = 1;
         #1;
         n_chk++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== (exp_data[i] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL prio_addr_ok[%0d]: got d/i=%b%b expected d=%b", i, data_sram_addr_ok, inst_sram_addr_ok, exp_data[i]); end
         n_chk++; if (mem_sram_addr !== (exp_data[i] ? data_sram_addr : inst_sram_addr)) begin n_fail++; $display("FAIL prio_addr[%0d]: got %h", i, mem_sram_addr); end
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         idle();
         mem_sram_data_ok = 1; mem_sram_rdata = 32'hA0 + 32'(i);
         #1;
         n_chk++; if ({data_sram_data_ok, inst_sram_data_ok} !== (exp_data[i] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL prio_ret[%0d]: got d/i=%b%b", i, data_sram_data_ok, inst_sram_data_ok); end
      end
   endtask

   task automatic test_lock();
      next_cycle(); idle();
      inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000;
      data_sram_addr = 32'h0000_2000;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) data_sram_req = 1;
         #1;
         n_chk++; if (mem_sram_addr !== 32'h1c00_0000) begin n_fail++; $display("FAIL lock_addr[%0d]: got %h expected 1c000000", c, mem_sram_addr); end
         n_chk++; if ({mem_sram_req, inst_sram_addr_ok, data_sram_addr_ok} !== 3'b100) begin n_fail++; $display("FAIL lock_stall[%0d]: got %b expected 100", c, {mem_sram_req, inst_sram_addr_ok, data_sram_addr_ok}); end
         next_cycle();
      end
      mem_sram_addr_ok = 1;
      #1;
      n_chk++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10 || mem_sram_addr !== 32'h1c00_0000) begin n_fail++; $display("FAIL lock_accept_inst: got i/d=%b%b addr=%h", inst_sram_addr_ok, data_sram_addr_ok, mem_sram_addr); end
      next_cycle();
      inst_sram_req = 0;
      #1;
      n_chk++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01 || mem_sram_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL lock_accept_data: got i/d=%b%b addr=%h", inst_sram_addr_ok, data_sram_addr_ok, mem_sram_addr); end
      next_cycle(); idle();
      mem_sram_data_ok = 1;
      #1;
      n_chk++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_ret0: got i/d=%b%b expected 10", inst_sram_data_ok, data_sram_data_ok); end
      next_cycle();
      #1;
      n_chk++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin n_fail++; $display("FAIL lock_ret1: got i/d=%b%b expected 01", inst_sram_data_ok, data_sram_data_ok); end
   endtask

   task automatic test_routing();
      logic [3:0]  own = 4'b0110;   // I, D, D, I
      logic [31:0] rd [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) begin
         next_cycle(); idle();
         inst_sram_req = ~own[i]; data_sram_req = own[i]; mem_sram_addr_ok = 1;
         #1;
         n_chk++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== (own[i] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL route_acc[%0d]: got d/i=%b%b", i, data_sram_addr_ok, inst_sram_addr_ok); end
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle(); idle();
         mem_sram_data_ok = 1; mem_sram_rdata = rd[i];
         #1;
         n_chk++; if ({data_sram_data_ok, inst_sram_data_ok} !== (own[i] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL route_ret[%0d]: got d/i=%b%b", i, data_sram_data_ok, inst_sram_data_ok); end
         n_chk++; if ((own[i] ? data_sram_rdata : inst_sram_rdata) !== rd[i]) begin n_fail++; $display("FAIL route_rdata[%0d]: got %h expected %h", i, own[i] ? data_sram_rdata : inst_sram_rdata, rd[i]); end
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         next_cycle(); idle(); inst_sram_req = 1; mem_sram_addr_ok = 1;
         #1;
         n_chk++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_fill[%0d]: got %b expected 1", i, inst_sram_addr_ok); end
      end
      next_cycle();
      #1;
      n_chk++; if ({mem_sram_req, inst_sram_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL full_block: got %b expected 00", {mem_sram_req, inst_sram_addr_ok}); end
      next_cycle(); mem_sram_data_ok = 1;
      #1;
      n_chk++; if ({mem_sram_req, inst_sram_data_ok} !== 2'b01) begin n_fail++; $display("FAIL full_pop_only: got req/dok=%b%b expected 01", mem_sram_req, inst_sram_data_ok); end
      next_cycle();
      #1;
      n_chk++; if ({inst_sram_addr_ok, inst_sram_data_ok} !== 2'b11) begin n_fail++; $display("FAIL full_push_pop: got aok/dok=%b%b expected 11", inst_sram_addr_ok, inst_sram_data_ok); end
      next_cycle(); mem_sram_data_ok = 0;
      #1;
      n_chk++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_count3: got %b expected 1", inst_sram_addr_ok); end
      next_cycle();
      #1;
      n_chk++; if (mem_sram_req !== 1'b0) begin n_fail++; $display("FAIL full_refull: got %b expected 0", mem_sram_req); end
      for (int i = 0; i < 4; i++) begin
         next_cycle(); idle(); mem_sram_data_ok = 1;
         #1;
         n_chk++; if (inst_sram_data_ok !== 1'b1) begin n_fail++; $display("FAIL full_drain[%0d]: got %b expected 1", i, inst_sram_data_ok); end
      end
      next_cycle(); idle(); mem_sram_data_ok = 1;
      #1;
      n_chk++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin n_fail++; $display("FAIL empty_stray: got %b expected 00", {inst_sram_data_ok, data_sram_data_ok}); end
   endtask

   task automatic test_write();
      next_cycle(); idle();
      data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2; data_sram_addr = 32'h8000_1234;
      data_sram_wstrb = 4'hF; data_sram_wdata = 32'hDEAD_BEEF; mem_sram_addr_ok = 1;
      #1;
      n_chk++; if ({mem_sram_req, mem_sram_wr, mem_sram_size, mem_sram_wstrb} !== {1'b1, 1'b1, 2'd2, 4'hF}) begin n_fail++; $display("FAIL wr_ctrl: got req=%b wr=%b size=%0d strb=%h", mem_sram_req, mem_sram_wr, mem_sram_size, mem_sram_wstrb); end
      n_chk++; if (mem_sram_wdata !== 32'hDEAD_BEEF || mem_sram_addr !== 32'h8000_1234) begin n_fail++; $display("FAIL wr_fields: got addr=%h wdata=%h", mem_sram_addr, mem_sram_wdata); end
      n_chk++; if (data_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b expected 1", data_sram_addr_ok); end
      next_cycle(); idle(); mem_sram_data_ok = 1;
      #1;
      n_chk++; if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b10) begin n_fail++; $display("FAIL wr_ret: got d/i=%b%b expected 10", data_sram_data_ok, inst_sram_data_ok); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         next_cycle(); idle(); data_sram_req = 1; mem_sram_addr_ok = 1;
      end
      next_cycle(); idle(); reset = 1; data_sram_req = 1; mem_sram_addr_ok = 1;
      #1;
      n_chk++; if ({mem_sram_req, data_sram_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL rstmid_req: got %b expected 00", {mem_sram_req, data_sram_addr_ok}); end
      next_cycle(); idle(); reset = 0; mem_sram_data_ok = 1;
      #1;
      n_chk++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin n_fail++; $display("FAIL rstmid_stray: got %b expected 00", {inst_sram_data_ok, data_sram_data_ok}); end
      // an emptied FIFO accepts exactly four more
      for (int i = 0; i < 5; i++) begin
         next_cycle(); idle(); inst_sram_req = 1; mem_sram_addr_ok = 1;
         #1;
         n_chk++; if (inst_sram_addr_ok !== (i < 4)) begin n_fail++; $display("FAIL rstmid_cap[%0d]: got %b expected %b", i, inst_sram_addr_ok, i < 4); end
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle(); idle(); mem_sram_data_ok = 1;
      end
      next_cycle(); idle();
   endtask

   initial begin
      reset = 1;
      idle();
      test_reset();
      test_priority();
      test_lock();
      test_routing();
      test_full();
      test_write();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
